// File: rtl/demux_1x2_32bit_buffered_pkg.sv
// rtl/demux_1x2_32bit_buffered_pkg.sv - shared constants and pointer-width helper
package demux_1x2_32bit_buffered_pkg;

  localparam int WORD_WIDTH = 32;

  localparam logic SEL_OUT0 = 1'b0;
  localparam logic SEL_OUT1 = 1'b1;

  // Pointers carry one extra wrap bit above the address bits.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/demux_1x2_32bit_buffered_fifo_sync_32bit.sv
// rtl/demux_1x2_32bit_buffered_fifo_sync_32bit.sv - synchronous FIFO with wrap-bit pointers
module fifo_sync_32bit
  import demux_1x2_32bit_buffered_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 2,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [PW-1:0]    count,
  output logic [WIDTH-1:0] head_data
);

  localparam int AW = PW - 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign count     = wr_ptr_q - rd_ptr_q;
  assign head_data = mem_q[rd_ptr_q[AW-1:0]];

  // Guard locally so a misbehaving caller cannot overrun or underrun.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/demux_1x2_32bit_buffered.sv
// rtl/demux_1x2_32bit_buffered.sv - 1:2 word demux steering into per-destination FIFOs
module demux_1x2_32bit_buffered
  import demux_1x2_32bit_buffered_pkg::*;
#(
  parameter int WIDTH = WORD_WIDTH,
  parameter int DEPTH = 2,
  localparam int PW = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [PW-1:0]    out0_count,
  output logic [PW-1:0]    out1_count
);

  logic full0, full1, empty0, empty1;
  logic push0, push1;

  // Ready looks only at registered full flags, so no ready-to-ready path exists.
  assign in_ready = (in_sel == SEL_OUT1) ? !full1 : !full0;
  assign push0    = in_valid && in_ready && (in_sel == SEL_OUT0);
  assign push1    = in_valid && in_ready && (in_sel == SEL_OUT1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  fifo_sync_32bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (in_data),
    .pop       (out0_ready),
    .full      (full0),
    .empty     (empty0),
    .count     (out0_count),
    .head_data (out0_data)
  );

  fifo_sync_32bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (in_data),
    .pop       (out1_ready),
    .full      (full1),
    .empty     (empty1),
    .count     (out1_count),
    .head_data (out1_data)
  );

endmodule

// File: doc/demux_1x2_32bit_buffered.md
Name: demux_1x2_32bit_buffered

Overview:
- 1-to-2 registered demultiplexer for 32-bit datapath words; the distribution counterpart of the 2:1 word selector.
- Accepts one word per cycle on a valid/ready input and steers it by a 1-bit select into one of two independent per-destination FIFOs. Example routing: writeback to register file vs. store path.
- Each destination drains through its own valid/ready port.
- A stalled destination never blocks traffic addressed to the other destination.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 2, entries per destination FIFO; power of two, at least 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_data  input  WIDTH  word to route.
- in_sel  input  1  0 routes to out0, 1 routes to out1.
- in_valid  input  1  in_data/in_sel valid this cycle.
- in_ready  output  1  block accepts the word this cycle.
- out0_data  output  WIDTH  head word of FIFO 0.
- out0_valid  output  1  FIFO 0 non-empty.
- out0_ready  input  1  consumer 0 takes head this cycle.
- out1_data  output  WIDTH  head word of FIFO 1.
- out1_valid  output  1  FIFO 1 non-empty.
- out1_ready  input  1  consumer 1 takes head this cycle.
- out0_count  output  log2(DEPTH)+1  occupancy of FIFO 0.
- out1_count  output  log2(DEPTH)+1  occupancy of FIFO 1.

Behaviour:
- Reset (rst_n low, asynchronous): all pointers and counts go to 0, storage is cleared to 0. As a result out*_valid=0, out*_data=0, out*_count=0. Words in flight are discarded. Reset may assert in any cycle and takes effect immediately.
- in_ready:
  - Combinational: equals !full of the FIFO named by in_sel.
  - Depends only on in_sel and registered full flags, never on out*_ready, so no combinational ready-to-ready path exists.
- Push: on an edge where in_valid && in_ready, in_data is written to FIFO[in_sel] at its write pointer and the write pointer increments.
- Pop: on an edge where outK_valid && outK_ready, FIFO K's read pointer increments.
- Latency: a word accepted at edge N appears on outK_data with outK_valid=1 after edge N. There is no same-cycle bypass.
- Data stability: outK_data equals the head entry and stays stable while outK_valid && !outK_ready.
- Pointers: log2(DEPTH)+1 bits with an extra wrap bit, wrapping modulo 2*DEPTH.
  - empty = (rd_ptr == wr_ptr)
  - full = (addr bits equal and wrap bits differ)
  - count = wr_ptr - rd_ptr, unsigned, truncated to pointer width.
- Full FIFO with a simultaneous pop: in_ready stays 0 for that FIFO, so there is no push that cycle. The freed slot is usable from the next cycle.
- Empty FIFO with simultaneous push: the word is written and valid rises next cycle. No pop occurs because valid was 0.
- Non-full, non-empty FIFO with simultaneous push and pop on the same edge: both happen and count is unchanged.
- in_sel change while in_valid && !in_ready: permitted. No word is committed until a handshake occurs.
- Ordering: FIFO order is preserved within each destination. No ordering is defined between destinations.
- outK_ready asserted while outK_valid=0: ignored.

Decomposition:
- Shared package:
  - WORD_WIDTH = 32.
  - SEL_OUT0 = 1'b0, SEL_OUT1 = 1'b1.
  - Pointer-width function clog2(DEPTH)+1.
- One sub-module, fifo_sync_32bit: parameterised WIDTH/DEPTH synchronous FIFO exposing push, pop, full, empty, count, and head data, with asynchronous active-low reset.
- The top level instantiates it twice and adds only the in_sel steering: push enables and in_ready mux.

Test Plan:
- Reset: assert rst_n=0 mid-stream with FIFO 0 holding 2 words → all valid=0, counts=0, data=0 immediately. After release, push 0x0000_0001 sel=0 → out0_valid=1 next cycle with data 0x0000_0001.
- Routing: push 0xDEAD_BEEF sel=0, then 0xCAFE_F00D sel=1, both readies=1 → out0 shows 0xDEAD_BEEF and out1 shows 0xCAFE_F00D, each one cycle after its acceptance edge. Counts return to 0.
- Independence: out0_ready=0, push 0x11, 0x22 sel=0 → out0_count=2, in_ready=0 when sel=0. Switching to sel=1 gives in_ready=1 and 0x33 is delivered on out1 while out0 holds 0x11 stable.
- Full with simultaneous pop: FIFO 1 full (0xA, 0xB), out1_ready=1, in_valid=1 sel=1 data 0xC → in_ready=0 that cycle and 0xA pops. Next cycle in_ready=1 and 0xC is accepted. Output order is 0xB then 0xC.
- Wrap-around: stream 10 words 0x100..0x109 on sel=0 with out0_ready toggling 1,0,1,0 → all 10 arrive in order and no duplicates or drops occur. The bench checks the count against its scoreboard every cycle.
- Push and pop on a half-full FIFO: FIFO 0 count=1 holding 0x55, push 0x66 sel=0 with out0_ready=1 on the same edge → 0x55 consumed, count stays 1, out0_data=0x66 next cycle.
